// File: rtl/dp_ram_arb.sv
// +----------------------------------------------------------------------------+
// | Module   : dp_ram_arb                                                      |
// | Desc     : True dual-port RAM with per-port handshake and write arbitration. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module dp_ram_arb #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int RD_LAT         = 1,
  parameter int COLL_MODE      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  localparam logic [ADDR_W-1:0] c_lastAddr = '1;
  localparam bit                c_collNew  = (COLL_MODE != 0);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clrCnt;
  logic              r_initDone;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_conflict;
  logic              w_aWr;
  logic              w_aRd;
  logic              w_bWr;
  logic              w_bRd;
  logic [DATA_W-1:0] w_aRdVal;
  logic [DATA_W-1:0] w_bRdVal;

  logic              r_aV1;
  logic              r_bV1;
  logic [DATA_W-1:0] r_aD1;
  logic [DATA_W-1:0] r_bD1;

  // Only a same-address write/write pair stalls port B; A always proceeds.
  assign w_conflict = a_req && a_we && b_req && b_we && (a_addr == b_addr);
  assign a_ready    = r_initDone;
  assign b_ready    = r_initDone && !w_conflict;
  assign init_done  = r_initDone;

  assign w_aWr = a_req && a_ready && a_we;
  assign w_aRd = a_req && a_ready && !a_we;
  assign w_bWr = b_req && b_ready && b_we;
  assign w_bRd = b_req && b_ready && !b_we;

  always_comb begin
    w_aRdVal = r_mem[a_addr];
    w_bRdVal = r_mem[b_addr];
    if (c_collNew && w_bWr && (b_addr == a_addr)) begin
      w_aRdVal = b_wdata;
    end
    if (c_collNew && w_aWr && (a_addr == b_addr)) begin
      w_bRdVal = a_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RESET;
      r_clrCnt   <= '0;
      r_initDone <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clrCnt <= r_clrCnt + 1'b1;
          if (r_clrCnt == c_lastAddr) begin
            r_state    <= ST_RUN;
            r_initDone <= 1'b1;
          end
        end
        default: begin
          r_initDone <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset; the sweep is the only way it gets initialised.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clrCnt] <= '0;
    end else begin
      if (w_aWr) begin
        r_mem[a_addr] <= a_wdata;
      end
      if (w_bWr) begin
        r_mem[b_addr] <= b_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aV1 <= 1'b0;
      r_bV1 <= 1'b0;
      r_aD1 <= '0;
      r_bD1 <= '0;
    end else begin
      r_aV1 <= w_aRd;
      r_bV1 <= w_bRd;
      if (w_aRd) begin
        r_aD1 <= w_aRdVal;
      end
      if (w_bRd) begin
        r_bD1 <= w_bRdVal;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_aV2;
      logic              r_bV2;
      logic [DATA_W-1:0] r_aD2;
      logic [DATA_W-1:0] r_bD2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_aV2 <= 1'b0;
          r_bV2 <= 1'b0;
          r_aD2 <= '0;
          r_bD2 <= '0;
        end else begin
          r_aV2 <= r_aV1;
          r_bV2 <= r_bV1;
          if (r_aV1) begin
            r_aD2 <= r_aD1;
          end
          if (r_bV1) begin
            r_bD2 <= r_bD1;
          end
        end
      end

      assign a_rvalid = r_aV2;
      assign a_rdata  = r_aD2;
      assign b_rvalid = r_bV2;
      assign b_rdata  = r_bD2;
    end else begin : g_lat1
      assign a_rvalid = r_aV1;
      assign a_rdata  = r_aD1;
      assign b_rvalid = r_bV1;
      assign b_rdata  = r_bD1;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dp_ram_arb.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_dp_ram_arb                                                   |
// | Desc     : Bench for dp_ram_arb; two instances (lat1/old, lat2/new) share stimulus. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dp_ram_arb;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MAXC  = 2048;

  typedef struct {
    logic          aReq;
    logic          aWe;
    logic [AW-1:0] aAddr;
    logic [DW-1:0] aWd;
    logic          bReq;
    logic          bWe;
    logic [AW-1:0] bAddr;
    logic [DW-1:0] bWd;
    logic          bRdy;
    logic          aV0;
    logic [DW-1:0] aD0;
    logic          bV0;
    logic [DW-1:0] bD0;
    logic          aV1;
    logic [DW-1:0] aD1;
    logic          bV1;
    logic [DW-1:0] bD1;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          aReq, aWe, bReq, bWe;
  logic [AW-1:0] aAddr, bAddr;
  logic [DW-1:0] aWdata, bWdata;

  logic          aRdy [2];
  logic          bRdy [2];
  logic          aRv  [2];
  logic          bRv  [2];
  logic [DW-1:0] aRd  [2];
  logic [DW-1:0] bRd  [2];
  logic          initDone [2];

  dp_ram_arb #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .COLL_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata),
    .a_ready(aRdy[0]), .a_rvalid(aRv[0]), .a_rdata(aRd[0]),
    .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata),
    .b_ready(bRdy[0]), .b_rvalid(bRv[0]), .b_rdata(bRd[0]),
    .init_done(initDone[0])
  );

  dp_ram_arb #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .COLL_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata),
    .a_ready(aRdy[1]), .a_rvalid(aRv[1]), .a_rdata(aRd[1]),
    .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata),
    .b_ready(bRdy[1]), .b_rvalid(bRv[1]), .b_rdata(bRd[1]),
    .init_done(initDone[1])
  );

  // Reference model: memory contents plus a cycle-indexed schedule of expected read returns.
  logic [DW-1:0] mMem [DEPTH];
  bit            mInit;
  int            mEdges;
  int            cyc;
  bit            expV [2][2][MAXC];
  logic [DW-1:0] expD [2][2][MAXC];
  logic [DW-1:0] lastD [2][2];
  logic          smpBRdy [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic setIn(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    aReq = ar; aWe = aw; aAddr = aa; aWdata = ad;
    bReq = br; bWe = bw; bAddr = ba; bWdata = bd;
  endtask

  task automatic idle();
    setIn(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic step();
    bit conflict, aAcc, bAcc;
    int lat;
    @(negedge clk);
    conflict = aReq && aWe && bReq && bWe && (aAddr == bAddr);
    aAcc = mInit && aReq;
    bAcc = mInit && bReq && !conflict;
    for (int d = 0; d < 2; d++) begin
      smpBRdy[d] = bRdy[d];
      chk("a_ready", {31'd0, aRdy[d]}, {31'd0, mInit});
      chk("b_ready", {31'd0, bRdy[d]}, {31'd0, mInit && !conflict});
      lat = (d == 0) ? 1 : 2;
      if (aAcc && !aWe) begin
        expV[d][0][cyc+lat] = 1'b1;
        expD[d][0][cyc+lat] = (d == 1 && bAcc && bWe && bAddr == aAddr) ? bWdata : mMem[aAddr];
      end
      if (bAcc && !bWe) begin
        expV[d][1][cyc+lat] = 1'b1;
        expD[d][1][cyc+lat] = (d == 1 && aAcc && aWe && aAddr == bAddr) ? aWdata : mMem[bAddr];
      end
    end
    if (aAcc && aWe) mMem[aAddr] = aWdata;
    if (bAcc && bWe) mMem[bAddr] = bWdata;
    @(posedge clk);
    #1;
    cyc++;
    mEdges++;
    if (!mInit && mEdges >= DEPTH) begin
      mInit = 1'b1;
      for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
    end
    for (int d = 0; d < 2; d++) begin
      logic [DW-1:0] ea, eb;
      chk("init_done", {31'd0, initDone[d]}, {31'd0, mInit});
      chk("a_rvalid", {31'd0, aRv[d]}, {31'd0, expV[d][0][cyc]});
      chk("b_rvalid", {31'd0, bRv[d]}, {31'd0, expV[d][1][cyc]});
      ea = expV[d][0][cyc] ? expD[d][0][cyc] : lastD[d][0];
      eb = expV[d][1][cyc] ? expD[d][1][cyc] : lastD[d][1];
      chk("a_rdata", {16'd0, aRd[d]}, {16'd0, ea});
      chk("b_rdata", {16'd0, bRd[d]}, {16'd0, eb});
      lastD[d][0] = ea;
      lastD[d][1] = eb;
    end
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    #1;
    mInit  = 1'b0;
    mEdges = 0;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        lastD[d][p] = '0;
        for (int c = cyc; c < MAXC; c++) expV[d][p][c] = 1'b0;
      end
      chk("rst_a_rvalid", {31'd0, aRv[d]}, 32'd0);
      chk("rst_b_rvalid", {31'd0, bRv[d]}, 32'd0);
      chk("rst_a_rdata", {16'd0, aRd[d]}, 32'd0);
      chk("rst_b_rdata", {16'd0, bRd[d]}, 32'd0);
      chk("rst_init_done", {31'd0, initDone[d]}, 32'd0);
      chk("rst_a_ready", {31'd0, aRdy[d]}, 32'd0);
    end
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input logic rdy,
                              input logic av0, input logic [DW-1:0] ad0, input logic bv0, input logic [DW-1:0] bd0,
                              input logic av1, input logic [DW-1:0] ad1, input logic bv1, input logic [DW-1:0] bd1);
    vec_t v;
    v.aReq = ar; v.aWe = aw; v.aAddr = aa; v.aWd = ad;
    v.bReq = br; v.bWe = bw; v.bAddr = ba; v.bWd = bd;
    v.bRdy = rdy;
    v.aV0 = av0; v.aD0 = ad0; v.bV0 = bv0; v.bD0 = bd0;
    v.aV1 = av1; v.aD1 = ad1; v.bV1 = bv1; v.bD1 = bd1;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int n;
    int pulses;
    cyc = 0;
    mInit = 1'b0;
    mEdges = 0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) lastD[d][p] = '0;
    for (int i = 0; i < DEPTH; i++) mMem[i] = 'x;

    // Directed table: {A in, B in, b_ready, u0 A/B returns, u1 A/B returns}
    vecs.push_back(mk(1,1,4'd3,16'hBEEF, 0,0,4'd0,16'h0,    1, 0,16'h0,   0,16'h0,    0,16'h0,    0,16'h0));
    vecs.push_back(mk(0,0,4'd0,16'h0,    1,0,4'd3,16'h0,    1, 0,16'h0,   1,16'hBEEF, 0,16'h0,    0,16'h0));
    vecs.push_back(mk(1,1,4'd5,16'h1111, 1,1,4'd5,16'h2222, 0, 0,16'h0,   0,16'h0,    0,16'h0,    1,16'hBEEF));
    vecs.push_back(mk(0,0,4'd0,16'h0,    1,1,4'd5,16'h2222, 1, 0,16'h0,   0,16'h0,    0,16'h0,    0,16'h0));
    vecs.push_back(mk(1,0,4'd5,16'h0,    0,0,4'd0,16'h0,    1, 1,16'h2222,0,16'h0,    0,16'h0,    0,16'h0));
    vecs.push_back(mk(1,1,4'd7,16'hAAAA, 0,0,4'd0,16'h0,    1, 0,16'h0,   0,16'h0,    1,16'h2222, 0,16'h0));
    vecs.push_back(mk(1,1,4'd7,16'h5555, 1,0,4'd7,16'h0,    1, 0,16'h0,   1,16'hAAAA, 0,16'h0,    0,16'h0));
    vecs.push_back(mk(0,0,4'd0,16'h0,    0,0,4'd0,16'h0,    1, 0,16'h0,   0,16'h0,    0,16'h0,    1,16'h5555));
    vecs.push_back(mk(1,0,4'd9,16'h0,    1,1,4'd9,16'h1234, 1, 1,16'h0000,0,16'h0,    0,16'h0,    0,16'h0));
    vecs.push_back(mk(0,0,4'd0,16'h0,    0,0,4'd0,16'h0,    1, 0,16'h0,   0,16'h0,    1,16'h1234, 0,16'h0));
    vecs.push_back(mk(1,1,4'd10,16'h0F0F,1,1,4'd11,16'hF0F0,1, 0,16'h0,   0,16'h0,    0,16'h0,    0,16'h0));
    vecs.push_back(mk(1,0,4'd11,16'h0,   1,0,4'd10,16'h0,   1, 1,16'hF0F0,1,16'h0F0F, 0,16'h0,    0,16'h0));
    vecs.push_back(mk(0,0,4'd0,16'h0,    0,0,4'd0,16'h0,    1, 0,16'h0,   0,16'h0,    1,16'hF0F0, 1,16'h0F0F));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,1,4'(i),16'(i*3), 0,0,4'd0,16'h0, 1, 0,16'h0,0,16'h0, 0,16'h0,0,16'h0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,0,4'(i),16'h0, 0,0,4'd0,16'h0, 1, 1,16'(i*3),0,16'h0,
                        (i > 0), (i > 0) ? 16'((i-1)*3) : 16'h0, 0,16'h0));
    vecs.push_back(mk(0,0,4'd0,16'h0, 0,0,4'd0,16'h0, 1, 0,16'h0,0,16'h0, 1,16'd21,0,16'h0));

    idle();
    #2;
    doReset(3);

    // Clear sweep: ready low and init_done exactly 16 cycles after release
    n = 0;
    while (!initDone[0] && n < 40) begin
      step();
      n++;
    end
    chk("init_latency", n, 32'd16);

    for (int i = 0; i < DEPTH; i++) begin
      setIn(1'b1, 1'b0, 4'(i), '0, 1'b0, 1'b0, '0, '0);
      step();
    end
    idle();
    repeat (2) step();

    foreach (vecs[k]) begin
      setIn(vecs[k].aReq, vecs[k].aWe, vecs[k].aAddr, vecs[k].aWd,
            vecs[k].bReq, vecs[k].bWe, vecs[k].bAddr, vecs[k].bWd);
      step();
      chk("tbl_b_ready", {31'd0, smpBRdy[0]}, {31'd0, vecs[k].bRdy});
      chk("tbl_a_rvalid0", {31'd0, aRv[0]}, {31'd0, vecs[k].aV0});
      chk("tbl_b_rvalid0", {31'd0, bRv[0]}, {31'd0, vecs[k].bV0});
      chk("tbl_a_rvalid1", {31'd0, aRv[1]}, {31'd0, vecs[k].aV1});
      chk("tbl_b_rvalid1", {31'd0, bRv[1]}, {31'd0, vecs[k].bV1});
      if (vecs[k].aV0) chk("tbl_a_rdata0", {16'd0, aRd[0]}, {16'd0, vecs[k].aD0});
      if (vecs[k].bV0) chk("tbl_b_rdata0", {16'd0, bRd[0]}, {16'd0, vecs[k].bD0});
      if (vecs[k].aV1) chk("tbl_a_rdata1", {16'd0, aRd[1]}, {16'd0, vecs[k].aD1});
      if (vecs[k].bV1) chk("tbl_b_rdata1", {16'd0, bRd[1]}, {16'd0, vecs[k].bD1});
    end

    // Random traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 300; i++) begin
      setIn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom));
      step();
    end
    idle();
    repeat (3) step();

    // Reset mid-clear at cnt=5, then a full 16-cycle sweep
    doReset(2);
    repeat (5) step();
    doReset(2);
    repeat (15) step();
    chk("midclr_init_lo", {31'd0, initDone[0]}, 32'd0);
    step();
    chk("midclr_init_hi", {31'd0, initDone[0]}, 32'd1);

    // Read accepted, then reset before the 2-cycle return can appear
    setIn(1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, '0, '0);
    step();
    idle();
    doReset(1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (aRv[1]) pulses++;
    end
    chk("midread_pulses", pulses, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
